// File: rtl/p_cache_arbiter_pkg.sv
// Shared types for the I/D cache arbiter.
// States and source ids used by the top and request register.
package cache_mux_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/p_arbiter_req_reg.sv
// Request register for the arbiter: holds the granted
// transaction's address, data, kind and source.
module p_arbiter_req_reg
  import cache_mux_types::*;
#(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [s_addr-1:0] load_addr,
  input  logic [s_line-1:0] load_wdata,
  input  logic              load_write,
  input  arb_src_t          load_src,
  output logic [s_addr-1:0] addr,
  output logic [s_line-1:0] wdata,
  output logic              is_write,
  output arb_src_t          src
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      wdata    <= '0;
      is_write <= 1'b0;
      src      <= SRC_I;
    end else if (load) begin
      addr     <= load_addr;
      wdata    <= load_wdata;
      is_write <= load_write;
      src      <= load_src;
    end
  end

endmodule

// File: rtl/p_cache_arbiter.sv
// Round-robin arbiter of I-cache and D-cache onto one
// line-granular memory port, with per-source grant counters.
module p_cache_arbiter
  import cache_mux_types::*;
#(
  parameter int s_line = 256,
  parameter int s_addr = 32,
  parameter int s_cnt  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [s_line-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_addr-1:0] mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [s_line-1:0] mem_rdata,
  output logic [s_cnt-1:0]  i_grant_count,
  output logic [s_cnt-1:0]  d_grant_count
);

  arb_state_t state, state_n;
  arb_src_t   last_grant;
  logic       grant_i, grant_d;
  logic       i_req, d_req;
  logic       serving;
  logic       req_write;
  arb_src_t   req_src;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the source not granted last wins
        grant_d = d_req & (~i_req | (last_grant == SRC_I));
        grant_i = i_req & ~grant_d;
        if (grant_d) state_n = SERVE_D;
        else if (grant_i) state_n = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= SRC_I;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else begin
      state <= state_n;
      if (grant_i) begin
        last_grant    <= SRC_I;
        i_grant_count <= i_grant_count + 1'b1;
      end
      if (grant_d) begin
        last_grant    <= SRC_D;
        d_grant_count <= d_grant_count + 1'b1;
      end
    end
  end

  p_arbiter_req_reg #(
    .s_line(s_line),
    .s_addr(s_addr)
  ) u_req (
    .clk       (clk),
    .rst       (rst),
    .load      (grant_i | grant_d),
    .load_addr (grant_d ? d_pmem_address : i_pmem_address),
    .load_wdata(grant_d ? d_pmem_wdata : '0),
    .load_write(grant_d & d_pmem_write),
    .load_src  (grant_d ? SRC_D : SRC_I),
    .addr      (mem_address),
    .wdata     (mem_wdata),
    .is_write  (req_write),
    .src       (req_src)
  );

  assign serving      = (state == SERVE_I) | (state == SERVE_D);
  assign mem_read     = serving & ~req_write;
  assign mem_write    = serving & req_write;
  assign i_pmem_resp  = serving & (req_src == SRC_I) & mem_resp;
  assign d_pmem_resp  = serving & (req_src == SRC_D) & mem_resp;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: doc/p_cache_arbiter.md
Name: p_cache_arbiter

Overview:
- Arbitrates the pipelined I-cache and the D-cache onto a single physical-memory port. That port feeds the cacheline burst adapter.
- Sits directly downstream of the I-cache miss path: it consumes the I-cache's pmem_read/pmem_address and returns pmem_resp/pmem_rdata.
- One outstanding line transaction at a time. Round-robin between the two caches under contention. Per-source grant counters for performance analysis.

Parameters:
- s_line, 256, cacheline width in bits.
- s_addr, 32, physical address width.
- s_cnt, 32, width of each grant counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_pmem_read  in  1  I-cache line-fill request
- i_pmem_address  in  s_addr  I-cache line address (bits [4:0] zero)
- i_pmem_resp  out  1  fill complete to I-cache
- i_pmem_rdata  out  s_line  fill data to I-cache
- d_pmem_read  in  1  D-cache fill request
- d_pmem_write  in  1  D-cache writeback request
- d_pmem_address  in  s_addr  D-cache line address
- d_pmem_wdata  in  s_line  D-cache writeback data
- d_pmem_resp  out  1  D-cache transaction complete
- d_pmem_rdata  out  s_line  fill data to D-cache
- mem_read  out  1  read request to adapter
- mem_write  out  1  write request to adapter
- mem_address  out  s_addr  latched transaction address
- mem_wdata  out  s_line  latched writeback data
- mem_resp  in  1  adapter completion
- mem_rdata  in  s_line  adapter read data
- i_grant_count  out  s_cnt  number of I-cache grants
- d_grant_count  out  s_cnt  number of D-cache grants

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high: sampled on the clk rising edge.
- States:
  - IDLE
  - SERVE_I
  - SERVE_D
  - DONE: exactly one cycle, lets the served cache drop its request.
- IDLE transitions:
  - Neither request pending → stay in IDLE.
  - Only I pending (i_pmem_read) → SERVE_I.
  - Only D pending (d_pmem_read|d_pmem_write) → SERVE_D.
  - Both pending → serve the source NOT granted last (last_grant flop). After reset last_grant=I, so D wins the first tie.
- Grant edge (IDLE→SERVE_x):
  - Latch address, read/write kind and wdata into a request register.
  - Increment the matching counter. Counters wrap at 2^s_cnt.
  - Update last_grant.
- Latency: a request visible in IDLE at cycle N drives mem_read/mem_write from cycle N+1.
- Memory-side outputs while in SERVE_x:
  - mem_read/mem_write are decoded from state plus the latched kind. Exactly one is high.
  - mem_address and mem_wdata come from the request register and stay stable for the whole transaction even if cache inputs change.
  - A D request with both read and write set is illegal. Write takes priority.
- Completion:
  - In SERVE_x, mem_resp is forwarded combinationally to x_pmem_resp in the same cycle.
  - mem_rdata is passed through to both i_pmem_rdata and d_pmem_rdata at all times.
  - The non-served resp stays 0.
  - On mem_resp → DONE.
- DONE:
  - Both mem_read and mem_write are 0 and both resps are 0.
  - Requests are ignored. Next state is IDLE.
  - A new request in IDLE the following cycle is therefore granted after a minimum 2-cycle gap between back-to-back transactions.
- Reset outputs:
  - State=IDLE, last_grant=I, request register=0, both counters=0.
  - mem_read, mem_write, i_pmem_resp, d_pmem_resp all 0 from the first cycle after the reset edge.
- Reset mid-transaction: the transaction is abandoned and mem_read/mem_write drop after the edge. Any mem_resp arriving in IDLE is ignored, not forwarded.
- A request asserted during SERVE_x or DONE for the other source is held by that cache. It is granted on return to IDLE; no request is lost.

Decomposition:
- Shared package cache_mux_types gains arb_state_t {IDLE, SERVE_I, SERVE_D, DONE} and arb_src_t {SRC_I, SRC_D}.
- Natural sub-module: p_arbiter_req_reg, a load-enabled register holding {address, wdata, is_write, src}.
- FSM and counters stay in the top module.

Test Plan:
- I-only fill: i_pmem_read=1, addr 0x0000_0060 at cycle 0; adapter resps at cycle 5 → mem_read=1 with mem_address=0x60 during cycles 1-5; i_pmem_resp=1 only in cycle 5; DONE at cycle 6; i_grant_count=1.
- Tie after reset: both requests at cycle 0 (D write to 0x100, I read of 0x40) → D served first (mem_write=1, mem_wdata latched), then I; I's mem_read is first seen at cycle resp_D+3.
- Round-robin: both caches hold requests continuously for 4 transactions → grant order D, I, D, I; both counters = 2.
- Stability: change d_pmem_address to 0xDEAD_BEE0 mid-SERVE_D → mem_address keeps its latched 0x100.
- Reset mid-SERVE_I: assert rst at cycle 3 → mem_read=0 at cycle 4, counters=0; mem_resp pulse at cycle 5 → no i_pmem_resp.
- Counter wrap, with s_cnt=2: 5 I grants → i_grant_count=1.
